// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: FSM state encoding and counter sizing.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        DEB_PRESS   = 2'b01,
        HELD        = 2'b10,
        DEB_RELEASE = 2'b11
    } btn_state_t;

    // Bits needed to hold 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages clear on reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta <= 1'b0;
            o_q  <= 1'b0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Debounced button with press/release pulses and optional auto-repeat.
// Auto-repeat is built only when BTN_CONDITIONER_AUTOREPEAT_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 10000,
    parameter int REPEAT_DELAY_CYCLES  = 500000,
    parameter int REPEAT_PERIOD_CYCLES = 100000,
    parameter bit ACTIVE_LOW           = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_event
);

    localparam int               DEB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

    logic             btn_sync;
    logic             s_btn;
    btn_state_t       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_d, press_d, release_d;

    sync_2ff u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_btn),
        .o_q       (btn_sync)
    );

    assign s_btn = ACTIVE_LOW ? ~btn_sync : btn_sync;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            o_level   <= level_d;
            o_press   <= press_d;
            o_release <= release_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        unique case (state_q)
            IDLE: begin
                deb_cnt_d = '0;
                if (s_btn) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = DEB_ONE;
                end
            end
            DEB_PRESS: begin
                if (!s_btn) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_MAX) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            HELD: begin
                deb_cnt_d = '0;
                if (!s_btn) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = DEB_ONE;
                end
            end
            DEB_RELEASE: begin
                if (s_btn) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_MAX) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so edges line up with o_level.
    always_comb begin
        level_d   = (state_d == HELD) || (state_d == DEB_RELEASE);
        press_d   = level_d && !o_level;
        release_d = !level_d && o_level;
    end

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int               RPT_W      = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY_CYCLES);
    localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD_CYCLES);
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_q;

    // Timer counts down to 1 and fires; a release in the same cycle suppresses it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rpt_cnt_q <= '0;
            rpt_q     <= 1'b0;
        end else begin
            rpt_q <= 1'b0;
            if (press_d) begin
                rpt_cnt_q <= RPT_DELAY;
            end else if (!level_d) begin
                rpt_cnt_q <= '0;
            end else if (rpt_cnt_q == RPT_ONE) begin
                rpt_q     <= 1'b1;
                rpt_cnt_q <= RPT_PERIOD;
            end else if (rpt_cnt_q != '0) begin
                rpt_cnt_q <= rpt_cnt_q - RPT_ONE;
            end
        end
    end

    assign o_repeat = rpt_q;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_event = o_press | o_repeat;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=3); repeat
// expectations follow BTN_CONDITIONER_AUTOREPEAT_EN.
module tb_btn_conditioner;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b0;
    logic btn       = 1'b0;
    logic btn_al    = 1'b1;

    logic o_level, o_press, o_release, o_repeat, o_event;
    logic al_level, al_press, al_release, al_repeat, al_event;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES      (DEB),
        .REPEAT_DELAY_CYCLES  (DLY),
        .REPEAT_PERIOD_CYCLES (PER),
        .ACTIVE_LOW           (1'b0)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn     (btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_repeat  (o_repeat),
        .o_event   (o_event)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES      (DEB),
        .REPEAT_DELAY_CYCLES  (DLY),
        .REPEAT_PERIOD_CYCLES (PER),
        .ACTIVE_LOW           (1'b1)
    ) dut_al (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn     (btn_al),
        .o_level   (al_level),
        .o_press   (al_press),
        .o_release (al_release),
        .o_repeat  (al_repeat),
        .o_event   (al_event)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        btn       = 1'b1;
        btn_al    = 1'b0;
        i_reset_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++;
            if ({o_level, o_press, o_release, o_repeat, o_event} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_outs c%0d: got %b want 00000", k,
                         {o_level, o_press, o_release, o_repeat, o_event});
            end
            n_cmp++;
            if ({al_level, al_press, al_release, al_repeat, al_event} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_al_outs c%0d: got %b want 00000", k,
                         {al_level, al_press, al_release, al_repeat, al_event});
            end
        end
        btn    = 1'b0;
        btn_al = 1'b1;
        step();
        i_reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if ({o_level, o_press, al_level, al_press} !== 4'b0) begin
                n_bad++;
                $display("FAIL post_reset_idle c%0d: got %b want 0000", k,
                         {o_level, o_press, al_level, al_press});
            end
        end
    endtask

    task automatic test_clean_press();
        btn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_cmp++;
            if (o_press !== (k == 7)) begin
                n_bad++;
                $display("FAIL press_pulse c%0d: got %b want %b", k, o_press, (k == 7));
            end
            n_cmp++;
            if (o_level !== (k >= 7) || o_release !== 1'b0) begin
                n_bad++;
                $display("FAIL press_level c%0d: got lvl=%b rel=%b want lvl=%b rel=0",
                         k, o_level, o_release, (k >= 7));
            end
        end
        btn = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_cmp++;
            if (o_release !== (k == 7)) begin
                n_bad++;
                $display("FAIL release_pulse c%0d: got %b want %b", k, o_release, (k == 7));
            end
            n_cmp++;
            if (o_level !== (k < 7) || o_press !== 1'b0) begin
                n_bad++;
                $display("FAIL release_level c%0d: got lvl=%b prs=%b want lvl=%b prs=0",
                         k, o_level, o_press, (k < 7));
            end
        end
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_bounce();
        int presses = 0;
        for (int k = 0; k < 4; k++) begin
            btn = (k % 2 == 0);
            step();
            if (o_press === 1'b1) presses++;
        end
        btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (o_press === 1'b1) presses++;
            n_cmp++;
            if (o_press !== (k == 7)) begin
                n_bad++;
                $display("FAIL bounce_press c%0d: got %b want %b", k, o_press, (k == 7));
            end
        end
        n_cmp++;
        if (presses != 1) begin
            n_bad++;
            $display("FAIL bounce_count: got %0d presses want 1", presses);
        end
        btn = 1'b0;
        for (int k = 0; k < 10; k++) step();
    endtask

    task automatic test_repeat();
        logic exp_rep;
        btn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_cmp++;
            if (o_event !== (k == 7)) begin
                n_bad++;
                $display("FAIL press_event c%0d: got %b want %b", k, o_event, (k == 7));
            end
        end
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_rep = RPT_EN && (k >= DLY) && ((k - DLY) % PER == 0);
            n_cmp++;
            if (o_repeat !== exp_rep || o_event !== exp_rep) begin
                n_bad++;
                $display("FAIL repeat P+%0d: got rep=%b evt=%b want %b", k, o_repeat, o_event, exp_rep);
            end
            n_cmp++;
            if (o_level !== 1'b1 || o_press !== 1'b0) begin
                n_bad++;
                $display("FAIL repeat_hold P+%0d: got lvl=%b prs=%b want lvl=1 prs=0", k, o_level, o_press);
            end
        end
    endtask

    task automatic test_release_on_repeat();
        logic exp_rep;
        btn = 1'b0;
        for (int k = 31; k <= 50; k++) begin
            step();
            exp_rep = RPT_EN && (k < 37) && ((k - DLY) % PER == 0);
            n_cmp++;
            if (o_repeat !== exp_rep || o_event !== exp_rep) begin
                n_bad++;
                $display("FAIL rel_repeat P+%0d: got rep=%b evt=%b want %b", k, o_repeat, o_event, exp_rep);
            end
            n_cmp++;
            if (o_release !== (k == 37) || o_level !== (k < 37)) begin
                n_bad++;
                $display("FAIL rel_pulse P+%0d: got rel=%b lvl=%b want rel=%b lvl=%b",
                         k, o_release, o_level, (k == 37), (k < 37));
            end
        end
    endtask

    task automatic test_reset_mid_held();
        btn = 1'b1;
        for (int k = 0; k < 10; k++) step();
        n_cmp++;
        if (o_level !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_held_setup: got lvl=%b want 1", o_level);
        end
        #3;
        i_reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_level, o_press, o_release, o_repeat, o_event} !== 5'b0) begin
            n_bad++;
            $display("FAIL async_reset_outs: got %b want 00000",
                     {o_level, o_press, o_release, o_repeat, o_event});
        end
        #1;
        i_reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (o_release !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_release c%0d: got %b want 0", k, o_release);
            end
            n_cmp++;
            if (o_press !== (k == 7) || o_level !== (k >= 7)) begin
                n_bad++;
                $display("FAIL reset_fresh_press c%0d: got prs=%b lvl=%b want prs=%b lvl=%b",
                         k, o_press, o_level, (k == 7), (k >= 7));
            end
        end
        btn = 1'b0;
        for (int k = 0; k < 10; k++) step();
    endtask

    task automatic test_active_low();
        btn_al = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (al_press !== (k == 7) || al_event !== (k == 7)) begin
                n_bad++;
                $display("FAIL al_press c%0d: got prs=%b evt=%b want %b", k, al_press, al_event, (k == 7));
            end
            n_cmp++;
            if (al_level !== (k >= 7) || al_repeat !== 1'b0) begin
                n_bad++;
                $display("FAIL al_level c%0d: got lvl=%b rep=%b want lvl=%b rep=0",
                         k, al_level, al_repeat, (k >= 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_release_on_repeat();
        test_reset_mid_held();
        test_active_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
